// File: rtl/fifo_pkg.sv
// Shared FIFO sizing defaults plus the pointer-increment and depth helpers
// used by the controller and its pointer registers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 4;
  localparam int FIFO_ADDR_WIDTH = 2;
  localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Advance a RAM pointer by one, wrapping back to entry 0 after the last entry
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1) % depth;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// RAM address pointer: advances by one entry on each accepted request and
// wraps modulo the FIFO depth.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= ADDR_WIDTH'(ptr_inc(32'(ptr), DEPTH));
  end

endmodule

// File: rtl/dualport_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (registered read).
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module dualport_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned         DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  rd_valid_q;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags come from the registered count, so accepts never depend on same-cycle requests
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign ram_write_en      = push_ok;
  assign ram_write_address = wr_ptr;
  assign ram_data_in       = push_data;
  assign ram_read_en       = pop_ok;
  assign ram_read_address  = rd_ptr;

  assign rd_data  = ram_data_out;
  assign rd_valid = rd_valid_q;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop_ok),
    .ptr (rd_ptr)
  );

  // rd_valid tracks the RAM's one-cycle read latency; reset kills any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)
        overflow <= 1'b1;
      if (pop & empty)
        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dualport_fifo_ctrl.sv
// Self-checking bench for dualport_fifo_ctrl with a behavioural 4x4 registered-read RAM.
// Honours FIFO_ERR_FLAGS_EN when defined.
module tb_dualport_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [3:0] push_data;
  logic       pop;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       ram_write_en;
  logic [1:0] ram_write_address;
  logic [3:0] ram_data_in;
  logic       ram_read_en;
  logic [1:0] ram_read_address;
  logic [3:0] ram_data_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] mem [4];
  logic [3:0] model_q [$];
  logic [3:0] exp_q [$];
  int         m_cnt;
  logic [1:0] m_wr;
  logic [1:0] m_rd;
  logic       m_ovf;
  logic       m_unf;

  always #5 clk = ~clk;

  dualport_fifo_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .push              (push),
    .push_data         (push_data),
    .pop               (pop),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .ram_write_en      (ram_write_en),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_read_en       (ram_read_en),
    .ram_read_address  (ram_read_address),
    .ram_data_out      (ram_data_out)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow          (overflow),
    .underflow         (underflow)
`endif
  );

  // Stand-in for dualport_rw: synchronous write, registered read
  always @(posedge clk) begin
    if (ram_write_en)
      mem[ram_write_address] <= ram_data_in;
    if (ram_read_en)
      ram_data_out <= mem[ram_read_address];
  end

  // Read-return monitor: every rd_valid must match the oldest expected word
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_rd_valid: rd_valid=1 rd_data=%h, required no read return", rd_data);
      end else begin
        logic [3:0] want;
        want = exp_q.pop_front();
        if (rd_data !== want) begin
          failures++;
          $display("[TB] FAIL rd_data: got %h, required %h", rd_data, want);
        end
      end
    end
  end

  task automatic check_flags(input string tag);
    checks++;
    if (count !== 3'(m_cnt) || full !== (m_cnt == 4) || empty !== (m_cnt == 0)) begin
      failures++;
      $display("[TB] FAIL %s count/full/empty: got %0d/%b/%b, required %0d/%b/%b",
               tag, count, full, empty, m_cnt, (m_cnt == 4), (m_cnt == 0));
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== m_ovf || underflow !== m_unf) begin
      failures++;
      $display("[TB] FAIL %s err_flags: got ovf=%b unf=%b, required ovf=%b unf=%b",
               tag, overflow, underflow, m_ovf, m_unf);
    end
`endif
  endtask

  // One clock of stimulus; checks combinational RAM drive, then registered state
  task automatic do_cycle(input logic p, input logic [3:0] d, input logic q, input string tag);
    logic push_ok;
    logic pop_ok;
    push      = p;
    push_data = d;
    pop       = q;
    #1;
    push_ok = p && (m_cnt < 4);
    pop_ok  = q && (m_cnt > 0);
    checks++;
    if (ram_write_en !== push_ok || ram_read_en !== pop_ok) begin
      failures++;
      $display("[TB] FAIL %s ram_enables: got we=%b re=%b, required we=%b re=%b",
               tag, ram_write_en, ram_read_en, push_ok, pop_ok);
    end
    if (push_ok) begin
      checks++;
      if (ram_write_address !== m_wr || ram_data_in !== d) begin
        failures++;
        $display("[TB] FAIL %s write_addr/data: got %0d/%h, required %0d/%h",
                 tag, ram_write_address, ram_data_in, m_wr, d);
      end
    end
    if (pop_ok) begin
      checks++;
      if (ram_read_address !== m_rd) begin
        failures++;
        $display("[TB] FAIL %s read_addr: got %0d, required %0d", tag, ram_read_address, m_rd);
      end
    end
    @(posedge clk);
    if (p && m_cnt == 4) m_ovf = 1'b1;
    if (q && m_cnt == 0) m_unf = 1'b1;
    if (pop_ok) begin
      exp_q.push_back(model_q.pop_front());
      m_rd = m_rd + 2'd1;
    end
    if (push_ok) begin
      model_q.push_back(d);
      m_wr = m_wr + 2'd1;
    end
    m_cnt = m_cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_flags(tag);
  endtask

  // Reset for one edge, optionally with a pop request present
  task automatic do_reset(input logic q, input string tag);
    rst  = 1'b1;
    push = 1'b0;
    pop  = q;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    pop  = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_cnt = 0;
    m_wr  = '0;
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_flags(tag);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s rd_valid: got %b, required 0", tag, rd_valid);
    end
  endtask

  task automatic drain_returns(input string tag);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s pending_returns: got %0d outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0, "reset");
    do_cycle(1'b0, 4'h0, 1'b0, "idle");
  endtask

  task automatic test_fill();
    logic [3:0] words [4];
    words = '{4'h4, 4'h8, 4'hF, 4'hE};
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, words[i], 1'b0, $sformatf("fill%0d", i));
  endtask

  task automatic test_full_reject();
    do_cycle(1'b1, 4'h1, 1'b0, "push_when_full");
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 4'h0, 1'b1, $sformatf("drain%0d", i));
    drain_returns("drain");
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [4];
    words = '{4'h3, 4'h5, 4'h6, 4'h9};
    do_cycle(1'b1, 4'h1, 1'b0, "pre1");
    do_cycle(1'b1, 4'h2, 1'b0, "pre2");
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, words[i], 1'b1, $sformatf("pushpop%0d", i));
    do_cycle(1'b1, 4'hC, 1'b0, "refill1");
    do_cycle(1'b1, 4'hD, 1'b0, "refill2");
    do_cycle(1'b1, 4'h7, 1'b1, "pushpop_full");
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 4'h0, 1'b1, $sformatf("tail%0d", i));
    drain_returns("back_to_back");
  endtask

  task automatic test_empty_reject();
    do_cycle(1'b1, 4'hA, 1'b1, "pushpop_when_empty");
    drain_returns("empty_reject");
    do_reset(1'b1, "reset_mid_stream");
    do_cycle(1'b0, 4'h0, 1'b0, "post_reset_idle");
  endtask

  initial begin
    rst       = 1'b1;
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    m_cnt     = 0;
    m_wr      = '0;
    m_rd      = '0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_full_reject();
    test_back_to_back();
    test_empty_reject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
